// File: rtl/uart_tx_mmio_responder_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, serializer state encoding.
package uart_tx_mmio_responder_pkg;

  localparam logic [2:0] UART_TXDATA_OFF = 3'd0;
  localparam logic [2:0] UART_STATUS_OFF = 3'd4;

  localparam int STATUS_FULL_BIT   = 0;
  localparam int STATUS_EMPTY_BIT  = 1;
  localparam int STATUS_BUSY_BIT   = 2;
  localparam int STATUS_OVF_BIT    = 3;
  localparam int STATUS_COUNT_LSB  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // Assemble the STATUS word from its individual fields.
  function automatic logic [31:0] pack_status(input logic [3:0] count,
                                              input logic       overflow,
                                              input logic       busy,
                                              input logic       empty,
                                              input logic       full);
    logic [31:0] word;
    word = 32'h0;
    word[STATUS_COUNT_LSB +: 4] = count;
    word[STATUS_OVF_BIT]        = overflow;
    word[STATUS_BUSY_BIT]       = busy;
    word[STATUS_EMPTY_BIT]      = empty;
    word[STATUS_FULL_BIT]       = full;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_responder_if.sv
// MEM-stage data bus as seen by a memory-mapped responder.
interface uart_tx_mmio_responder_if;
  logic [31:0] me_address_in;
  logic        me_memory_write_in;
  logic        me_memory_read_in;
  logic [31:0] me_memory_data_write_in;
  logic [31:0] me_memory_data_read_out;

  modport master (
    output me_address_in, me_memory_write_in, me_memory_read_in,
           me_memory_data_write_in,
    input  me_memory_data_read_out
  );

  modport slave (
    input  me_address_in, me_memory_write_in, me_memory_read_in,
           me_memory_data_write_in,
    output me_memory_data_read_out
  );
endinterface

// File: rtl/uart_tx_mmio_responder_fifo.sv
// Byte FIFO feeding the serializer. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Byte storage.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; the pointers and count alone
    // decide which entries are valid, so stale contents are never read.
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio_responder.sv
// Memory-mapped UART transmitter: TXDATA stores feed a FIFO drained as
// 8N1 frames, LSB first; STATUS loads return FIFO/serializer state.
module uart_tx_mmio_responder
  import uart_tx_mmio_responder_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  uart_tx_mmio_responder_if.slave  bus,
  output logic                     uart_tx_out,
  output logic                     tx_busy_out
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Bus decode
  logic          w_hit;
  logic          w_is_status;
  logic          w_push;
  logic          w_status_rd;
  logic          w_unused_bits;

  // FIFO interface
  logic          w_pop;
  logic [7:0]    w_fifo_rdata;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  // Serializer
  tx_state_t     r_state, w_state_next;
  logic [BW-1:0] r_baud, w_baud_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_tx, w_tx_next;
  logic          w_baud_done;
  logic          r_overflow;

  assign w_hit       = (bus.me_address_in[31:3] == BASE_ADDRESS[31:3]);
  assign w_is_status = (bus.me_address_in[2] == UART_STATUS_OFF[2]);
  assign w_push      = bus.me_memory_write_in && w_hit && !w_is_status;
  assign w_status_rd = bus.me_memory_read_in && w_hit && w_is_status;
  assign w_unused_bits = &{1'b0, bus.me_address_in[1:0],
                           bus.me_memory_data_write_in[31:8],
                           UART_TXDATA_OFF, UART_STATUS_OFF[1:0]};

  assign tx_busy_out = !w_empty || (r_state != S_IDLE);
  assign uart_tx_out = r_tx;

  assign bus.me_memory_data_read_out =
    w_status_rd ? pack_status(4'(w_count), r_overflow, tx_busy_out, w_empty, w_full)
                : 32'h0;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (bus.me_memory_data_write_in[7:0]),
    .rdata (w_fifo_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Sticky overflow: set on a dropped byte, cleared by a STATUS load that
  // is not accompanied by a store.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_status_rd && !bus.me_memory_write_in) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_baud_done = (r_baud == BW'(CLKS_PER_BIT - 1));

  // Serializer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Serializer next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty)                          w_state_next = S_START;
      S_START: if (w_baud_done)                       w_state_next = S_DATA;
      S_DATA:  if (w_baud_done && r_bit_idx == 3'd7)  w_state_next = S_STOP;
      S_STOP:  if (w_baud_done)                       w_state_next = S_IDLE;
      default:                                        w_state_next = S_IDLE;
    endcase
  end

  // Serializer outputs: pop strobe, datapath next values and next line level.
  always_comb begin
    w_pop          = (r_state == S_IDLE) && !w_empty;
    w_shift_next   = w_pop ? w_fifo_rdata : r_shift;
    w_baud_next    = (r_state == S_IDLE || w_baud_done) ? '0 : r_baud + BW'(1);
    w_bit_idx_next = 3'd0;
    if (r_state == S_DATA)
      w_bit_idx_next = w_baud_done ? r_bit_idx + 3'd1 : r_bit_idx;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[w_bit_idx_next];
      default: w_tx_next = 1'b1;
    endcase
  end

  // Serializer datapath registers; the line is registered so it never glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio_responder.sv
// Scoreboard bench for uart_tx_mmio_responder: stimulus updates a queue-based
// reference model and queues expectations; a monitor decodes serial frames
// and compares per-cycle bus outputs.
module tb_uart_tx_mmio_responder;

  localparam int          CPB    = 4;
  localparam int          DEPTH  = 4;
  localparam int          PERIOD = 10 * CPB + 1;
  localparam int          FBITS  = 10 * CPB;
  localparam logic [31:0] BASE   = 32'hFFFF_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic uart_tx_out;
  logic tx_busy_out;

  uart_tx_mmio_responder_if bus();

  uart_tx_mmio_responder #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .uart_tx_out (uart_tx_out),
    .tx_busy_out (tx_busy_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, the edge at which the
  // serializer can next take a byte, and the sticky overflow flag.
  typedef struct { logic [7:0] data; int start; } frame_t;
  typedef struct { logic [31:0] rd; logic busy; } exp_t;

  logic [7:0] fifo_q[$];
  frame_t     frame_q[$];
  exp_t       exp_q[$];
  logic       m_ovf    = 1'b0;
  int         ser_free = 0;

  function automatic logic hit(input logic [31:0] a);
    return a[31:3] == BASE[31:3];
  endfunction

  // Drive one bus cycle, queue the expected same-cycle outputs, then apply
  // the edge to the model.
  task automatic bus_cycle(input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] data);
    exp_t x;
    int   e;
    logic do_pop;
    bus.me_memory_write_in      = wr;
    bus.me_memory_read_in       = rd;
    bus.me_address_in           = addr;
    bus.me_memory_data_write_in = data;
    x.busy = (fifo_q.size() != 0) || (cyc < ser_free - 1);
    x.rd   = 32'h0;
    if (rd && hit(addr) && addr[2])
      x.rd = {24'h0, 4'(fifo_q.size()), m_ovf, x.busy,
              fifo_q.size() == 0, fifo_q.size() == DEPTH};
    exp_q.push_back(x);
    e = cyc + 1;
    @(posedge clock);
    do_pop = (fifo_q.size() != 0) && (e >= ser_free);
    if (do_pop) begin
      frame_t f;
      f.data = fifo_q.pop_front();
      f.start = e;
      frame_q.push_back(f);
      ser_free = e + PERIOD;
    end
    if (wr && hit(addr) && !addr[2]) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(data[7:0]);
      else                       m_ovf = 1'b1;
    end
    if (rd && hit(addr) && addr[2] && !wr) m_ovf = 1'b0;
    #1;
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus_cycle(1'b1, 1'b0, addr, data);
  endtask

  task automatic load(input logic [31:0] addr);
    bus_cycle(1'b0, 1'b1, addr, $urandom);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || cyc < ser_free) && n < budget) begin
      idle();
      n++;
    end
    check("drain_in_budget", n < budget, 1'b1);
  endtask

  // Asserted mid-cycle, away from any clock edge.
  task automatic do_reset(input int hold);
    bus.me_memory_write_in = 1'b0;
    bus.me_memory_read_in  = 1'b0;
    bus.me_address_in      = 32'h0;
    reset = 1'b1;
    #1;
    check("reset_line", uart_tx_out, 1'b1);
    check("reset_busy", tx_busy_out, 1'b0);
    check("reset_rdata", bus.me_memory_data_read_out, 32'h0);
    repeat (hold) @(posedge clock);
    #1;
    reset = 1'b0;
    fifo_q.delete();
    frame_q.delete();
    exp_q.delete();
    m_ovf    = 1'b0;
    ser_free = 0;
  endtask

  // Monitor: per-cycle bus output checks and serial frame decoding.
  initial begin : monitor
    bit          coll = 1'b0;
    bit          have = 1'b0;
    int          k = 0;
    logic [63:0] got = '0;
    logic [63:0] want = '0;
    exp_t        x;
    frame_t      f;
    forever begin
      @(negedge clock);
      if (reset) begin
        coll = 1'b0;
        continue;
      end
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("read_data", bus.me_memory_data_read_out, x.rd);
        check("tx_busy", tx_busy_out, x.busy);
      end
      if (!coll && uart_tx_out === 1'b0) begin
        coll = 1'b1;
        k    = 0;
        got  = '0;
        have = frame_q.size() > 0;
        check("frame_expected", have, 1'b1);
        if (have) begin
          f = frame_q.pop_front();
          check("frame_start_cycle", cyc, f.start);
          want = '0;
          for (int i = 0; i < FBITS; i++) begin
            if (i < CPB)            want[i] = 1'b0;
            else if (i < 9 * CPB)   want[i] = f.data[(i - CPB) / CPB];
            else                    want[i] = 1'b1;
          end
        end
      end
      if (coll) begin
        got[k] = uart_tx_out;
        k++;
        if (k == FBITS) begin
          if (have) check("frame_bits", got, want);
          coll = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] burst [5];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55;
    bus.me_memory_write_in      = 1'b0;
    bus.me_memory_read_in       = 1'b0;
    bus.me_address_in           = 32'h0;
    bus.me_memory_data_write_in = 32'h0;

    do_reset(3);
    repeat (50) idle();
    check("idle_line", uart_tx_out, 1'b1);
    load(BASE + 32'd4);

    // Single byte
    store(BASE, 32'h0000_00A5);
    drain(100);
    load(BASE + 32'd4);

    // Five back-to-back stores: first is popped at once, no overflow
    for (int i = 0; i < 5; i++) store(BASE, {24'h0, burst[i]});
    load(BASE + 32'd4);
    drain(400);
    load(BASE + 32'd4);

    // Six consecutive stores: sixth dropped, overflow cleared by reading
    for (int i = 0; i < 6; i++) store(BASE, 32'h60 + i);
    load(BASE + 32'd4);
    load(BASE + 32'd4);
    load(BASE + 32'd4);
    drain(400);

    // Reset during data bit 3 of a zero byte
    store(BASE, 32'h0000_0000);
    repeat (2 + CPB * 4) idle();
    check("pre_reset_line", uart_tx_out, 1'b0);
    do_reset(2);
    load(BASE + 32'd4);
    repeat (60) idle();

    // Non-STATUS loads, STATUS stores, both strobes together
    load(BASE);
    load(32'h0000_0040);
    store(BASE + 32'd4, 32'h0000_00FF);
    load(BASE + 32'd4);
    for (int i = 0; i < 6; i++) store(BASE + 32'd1, 32'h80 + i);
    bus_cycle(1'b1, 1'b1, BASE + 32'd4, 32'h0);
    load(BASE + 32'd6);
    bus_cycle(1'b1, 1'b1, BASE, 32'hC3);
    load(BASE + 32'd4);
    drain(400);

    // Randomised phases with varying store density
    for (int p = 0; p < 15; p++) begin
      int sp;
      sp = $urandom_range(1, 60);
      repeat (200) begin
        int          r;
        logic [31:0] lo;
        r  = $urandom_range(0, 99);
        lo = {30'h0, 2'($urandom)};
        if (r < sp)            store(BASE | lo, $urandom);
        else if (r < sp + 10)  load(BASE | 32'd4 | lo);
        else if (r < sp + 14)  load(BASE | lo);
        else if (r < sp + 17)  store(BASE | 32'd4 | lo, $urandom);
        else if (r < sp + 20)  load($urandom);
        else if (r < sp + 22)  bus_cycle(1'b1, 1'b1, BASE | {29'h0, 3'($urandom)}, $urandom);
        else if (r < sp + 24)  store($urandom & 32'h0FFF_FFFF, $urandom);
        else                   idle();
      end
    end
    drain(1000);
    check("frames_outstanding", frame_q.size(), 0);
    check("line_idle_end", uart_tx_out, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
